// File: rtl/lx32_pipe_pkg.sv
// Shared definitions for the lx32 pipeline skid register: state encoding,
// buffer depth and the state-to-occupancy mapping.
package lx32_pipe_pkg;

  localparam logic [1:0] SKID_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Illegal encodings report as empty so no phantom beat is ever offered.
  function automatic logic [1:0] skid_occupancy(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream write side, downstream read
// side, squash control and occupancy status.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer. All outputs come straight from registers,
// so neither ready nor data has a combinational path through this stage.
module pipe_skid_reg
  import lx32_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  pipe_skid_reg_if.slave bus
);

  skid_state_e      state_q;
  skid_state_e      state_d_s;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [1:0]       occ_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_en_s;
  logic             main_from_skid_s;
  logic             skid_en_s;

  assign occ_s         = skid_occupancy(state_q);
  assign bus.occupancy = occ_s;
  assign bus.out_valid = (occ_s != 2'd0);
  assign bus.in_ready  = (occ_s != SKID_DEPTH);
  assign bus.out_data  = main_q;

  assign in_fire_s  = bus.in_valid & bus.in_ready;
  assign out_fire_s = bus.out_valid & bus.out_ready;

  // Next state and data-register enables; flush overrides every transfer.
  always_comb begin
    state_d_s        = state_q;
    main_en_s        = 1'b0;
    main_from_skid_s = 1'b0;
    skid_en_s        = 1'b0;
    if (bus.flush) begin
      state_d_s = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_s) begin
            state_d_s = BUSY;
            main_en_s = 1'b1;
          end else begin
            state_d_s = EMPTY;
          end
        end
        BUSY: begin
          case ({in_fire_s, out_fire_s})
            2'b11: begin
              state_d_s = BUSY;
              main_en_s = 1'b1;
            end
            2'b10: begin
              state_d_s = FULL;
              skid_en_s = 1'b1;
            end
            2'b01:   state_d_s = EMPTY;
            default: state_d_s = BUSY;
          endcase
        end
        FULL: begin
          // The older beat sits in main_q; the skid entry moves up behind it.
          if (out_fire_s) begin
            state_d_s        = BUSY;
            main_en_s        = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_d_s = FULL;
          end
        end
        default: state_d_s = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d_s;
    end
  end

  // Head-of-buffer payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= {WIDTH{1'b0}};
    end else if (main_en_s) begin
      main_q <= main_from_skid_s ? skid_q : bus.in_data;
    end else begin
      main_q <= main_q;
    end
  end

  // Second-entry payload register, written only when main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= {WIDTH{1'b0}};
    end else if (skid_en_s) begin
      skid_q <= bus.in_data;
    end else begin
      skid_q <= skid_q;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios then random traffic,
// checked against a two-slot FIFO reference held as a queue.
module tb_pipe_skid_reg;

  logic clk;
  logic rst_n;

  pipe_skid_reg_if #(.WIDTH(32)) bus ();

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb[$];
  logic        pend_in;
  logic        pend_flush;
  logic [31:0] pend_data;
  int          tests;
  int          fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Commit the previous edge's effect on the model, then drive new inputs.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    if (pend_flush) sb.delete();
    else if (pend_in) sb.push_back(pend_data);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    pend_in    = v && (sb.size() < 2) && rst_n;
    pend_flush = fl;
    pend_data  = d;
  endtask

  // Monitor: compare status against the model and pop on each out-transfer.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("occupancy", {30'd0, bus.occupancy}, sb.size());
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() > 0});
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, sb.size() < 2});
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", bus.out_data, 32'hxxxxxxxx);
        end else begin
          chk("out_data", bus.out_data, sb[0]);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    pend_in = 1'b0;
    pend_flush = 1'b0;
    pend_data = 32'd0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held with a live beat on the input.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_occupancy", {30'd0, bus.occupancy}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_data",  bus.out_data,           32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Streaming.
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure, third beat held upstream, then stall stability.
    step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
    repeat (5) step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while FULL with a simultaneous input beat.
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    #1;
    chk("flush_occupancy", {30'd0, bus.occupancy}, 32'd0);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_occupancy", {30'd0, bus.occupancy}, 32'd0);
    chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    sb.delete();
    pend_in = 1'b0;
    pend_flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3);
    end
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry valid/ready pipeline register (skid buffer), inserted between core pipeline stages.
- The upstream side writes through an `in_valid`/`in_ready` handshake; the downstream side reads through `out_valid`/`out_ready`.
- Registered `in_ready` breaks the combinational ready path and still sustains one transfer per cycle.
- Synchronous `flush` supports pipeline squash on branch or trap.

Parameters:
WIDTH, 32, payload width in bits (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash; empties the buffer
in_valid  input  1  upstream payload valid
in_ready  output  1  buffer can accept (registered, derived from state only)
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream consumer accepts
out_data  output  WIDTH  downstream payload (main entry)
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Interface (decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Storage: `main_q` and `skid_q` (WIDTH each); state register `state_q`.
- Reset (`rst_n` = 0, async): `state_q`=EMPTY, `main_q`=`skid_q`=0.
  - Hence `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=1.
  - No transfer is captured while `rst_n` is low.
  - Reset asserted mid-operation discards all held entries immediately.
- Transfers:
  - In-transfer = `in_valid` & `in_ready` at a rising edge.
  - Out-transfer = `out_valid` & `out_ready` at a rising edge.
- Outputs (all pure functions of registers; no input-to-output combinational path):
  - `out_valid` = (`state_q` != EMPTY).
  - `in_ready` = (`state_q` != FULL).
  - `out_data` = `main_q`.
  - `occupancy` = 0 / 1 / 2 for EMPTY / BUSY / FULL.
- State machine (flush = 0):
  - EMPTY: in-transfer -> BUSY, `main_q` <= `in_data`; else stay.
  - BUSY, in+out transfer -> BUSY, `main_q` <= `in_data`.
  - BUSY, in only -> FULL, `skid_q` <= `in_data`.
  - BUSY, out only -> EMPTY.
  - BUSY, neither -> hold.
  - FULL (`in_ready`=0): out-transfer -> BUSY, `main_q` <= `skid_q`; else hold.
- Latency: 1 cycle from in-transfer to `out_valid`. Throughput: 1 beat/cycle in steady state with `out_ready`=1.
- Ordering: strict FIFO; no drop or duplication except on flush/reset.
- Stall stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable.
- Flush (synchronous, highest priority):
  - Next state = EMPTY.
  - A simultaneous in-transfer is discarded.
  - A simultaneous out-transfer still completes on the bus, since the consumer already sampled it.
  - Data registers need not be cleared.
- Invalid encodings of `state_q` recover to EMPTY on the next edge.
- Unused `in_data` while `in_valid`=0 is never captured.

Decomposition:
- Shared package `lx32_pipe_pkg`:
  - typedef enum logic [1:0] `skid_state_e` {EMPTY, BUSY, FULL}.
  - Localparam `SKID_DEPTH` = 2.
- Single module; no sub-module required.
- Data registers are plain enable flops with async active-low reset, inline.

Test Plan:
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1, `in_data`=32'hDEADBEEF -> `out_valid`=0, `occupancy`=0, `in_ready`=1; nothing captured after release.
- Streaming: `out_ready`=1, push 32'h1, 32'h2, 32'h3 on consecutive cycles -> `out_data` shows 1, 2, 3 on consecutive cycles starting 1 cycle after each push; `in_ready` stays 1.
- Backpressure:
  - `out_ready`=0, push 32'hA5A5A5A5 then 32'h5A5A5A5A -> `occupancy`=2, `in_ready`=0.
  - A third beat 32'hFFFFFFFF is held upstream.
  - Release `out_ready` -> outputs A5A5A5A5, 5A5A5A5A, FFFFFFFF in order, none lost.
- Stall stability: `out_valid`=1 with `out_ready`=0 for 5 cycles -> `out_data` constant at the held value every cycle.
- Flush:
  - FULL state plus simultaneous `flush`=1 and `in_valid`=1 (32'h77) -> next cycle `occupancy`=0, `out_valid`=0.
  - 32'h77 never appears at the output.
- Async reset mid-operation: assert `rst_n`=0 between clock edges while FULL -> `out_valid` drops to 0 before the next rising edge; `occupancy`=0.
